// File: rtl/alu_seq.sv
// Multi-cycle accumulator ALU: single-cycle logic/arith ops, bit-serial shifts
// and a shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a_is_zero,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             out_is_zero,
    output logic             busy,
    output logic             done
);
    localparam int SH = $clog2(WIDTH);
    localparam int CW = SH + 1;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_PASSB = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_ADC   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_SHR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1101;
    localparam logic [3:0] OP_NOT   = 4'b1110;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     sh;
    logic [WIDTH-1:0]     sh_nxt;
    logic [WIDTH-1:0]     res;
    logic                 sh_left;
    logic                 sh_c;
    logic                 res_c;
    logic                 is_shift;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        k;

    assign a_is_zero = ~|in_a;
    assign busy      = (state != IDLE);
    assign k         = CW'(in_b[SH-1:0]);
    assign is_shift  = (opcode == OP_SHL) || (opcode == OP_SHR);

    // Pass-A opcodes and zero-distance shifts fall through to the defaults
    always_comb begin
        res   = in_a;
        res_c = carry;
        unique case (opcode)
            OP_ADD:   {res_c, res} = {1'b0, in_a} + {1'b0, in_b};
            OP_AND:   res = in_a & in_b;
            OP_XOR:   res = in_a ^ in_b;
            OP_PASSB: res = in_b;
            OP_SUB:   {res_c, res} = {1'b0, in_a} - {1'b0, in_b};
            OP_OR:    res = in_a | in_b;
            OP_ADC:   {res_c, res} = {1'b0, in_a} + {1'b0, in_b}
                                   + {{WIDTH{1'b0}}, carry};
            OP_NOT:   res = ~in_a;
            default:  ;
        endcase
    end

    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        sh_nxt  = sh_left ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        sh_c    = sh_left ? sh[WIDTH-1] : sh[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            alu_out     <= '0;
            carry       <= 1'b0;
            out_is_zero <= 1'b1;
            done        <= 1'b0;
            cnt         <= '0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            sh          <= '0;
            sh_left     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (opcode == OP_MUL) begin
                            state  <= MUL;
                            cnt    <= CW'(WIDTH);
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, in_a};
                            mplier <= in_b;
                        end else if (is_shift && k != '0) begin
                            state   <= SHIFT;
                            cnt     <= k;
                            sh      <= in_a;
                            sh_left <= (opcode == OP_SHL);
                        end else begin
                            alu_out     <= res;
                            carry       <= res_c;
                            out_is_zero <= (res == '0);
                            done        <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sh  <= sh_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= IDLE;
                        alu_out     <= sh_nxt;
                        carry       <= sh_c;
                        out_is_zero <= (sh_nxt == '0);
                        done        <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Final partial product lands straight in the outputs
                    if (cnt == CW'(1)) begin
                        state       <= IDLE;
                        alu_out     <= acc_nxt[WIDTH-1:0];
                        carry       <= |acc_nxt[2*WIDTH-1:WIDTH];
                        out_is_zero <= (acc_nxt[WIDTH-1:0] == '0);
                        done        <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expected results,
// an independent monitor pops and compares on every done pulse.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] opcode;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       a_is_zero;
    logic [7:0] alu_out;
    logic       carry;
    logic       out_is_zero;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] o;
        logic       c;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .in_a(in_a), .in_b(in_b), .a_is_zero(a_is_zero),
        .alu_out(alu_out), .carry(carry), .out_is_zero(out_is_zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            check("done_busy_excl", busy, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("alu_out", alu_out, e.o);
                check("carry", carry, e.c);
                check("out_is_zero", out_is_zero, e.z);
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic ec,
                          input int exp_lat, input int exp_busy,
                          input bit disturb);
        int lat;
        int nb;
        exp_t e;
        @(negedge clk);
        opcode = op;
        in_a   = a;
        in_b   = b;
        start  = 1'b1;
        e.o = eo;
        e.c = ec;
        e.z = (eo == 8'h00);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            if (disturb && lat == 3) begin
                start  = 1'b1;
                opcode = 4'b0010;
                in_a   = 8'hFF;
                in_b   = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, done, 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        exp_t e;
        rst    = 1'b1;
        start  = 1'b1;
        opcode = 4'b0010;
        in_a   = 8'h00;
        in_b   = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_out", alu_out, 8'h00);
        check("rst_carry", carry, 0);
        check("rst_out_is_zero", out_is_zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("a_is_zero_hi", a_is_zero, 1);
        in_a = 8'h05;
        #1;
        check("a_is_zero_lo", a_is_zero, 0);
        rst   = 1'b0;
        start = 1'b0;

        run_op("add", 4'b0010, 8'hF0, 8'h20, 8'h10, 1'b1, 1, 0, 0);
        run_op("adc", 4'b1010, 8'h01, 8'h01, 8'h03, 1'b0, 1, 0, 0);
        run_op("sub", 4'b1000, 8'h05, 8'h07, 8'hFE, 1'b1, 1, 0, 0);
        run_op("xor", 4'b0100, 8'h5A, 8'h5A, 8'h00, 1'b1, 1, 0, 0);
        run_op("shl1", 4'b1011, 8'h81, 8'h01, 8'h02, 1'b1, 2, 1, 0);
        run_op("shl3", 4'b1011, 8'h81, 8'h03, 8'h08, 1'b0, 4, 3, 0);
        run_op("shr0", 4'b1100, 8'h81, 8'h00, 8'h81, 1'b0, 1, 0, 0);
        run_op("shr2", 4'b1100, 8'h81, 8'h02, 8'h20, 1'b0, 3, 2, 0);
        run_op("or", 4'b1001, 8'h0F, 8'h30, 8'h3F, 1'b0, 1, 0, 0);
        run_op("not", 4'b1110, 8'h0F, 8'h00, 8'hF0, 1'b0, 1, 0, 0);
        run_op("passb", 4'b0101, 8'h12, 8'h77, 8'h77, 1'b0, 1, 0, 0);
        run_op("passa7", 4'b0111, 8'h00, 8'h77, 8'h00, 1'b0, 1, 0, 0);
        run_op("mul13x11", 4'b1101, 8'd13, 8'd11, 8'h8F, 1'b0, 9, 8, 1);
        run_op("mul20x20", 4'b1101, 8'd20, 8'd20, 8'h90, 1'b1, 9, 8, 0);

        // Abort a multiply with reset four edges in
        @(negedge clk);
        opcode = 4'b1101;
        in_a   = 8'd9;
        in_b   = 8'd9;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_alu_out", alu_out, 8'h00);
        check("abort_carry", carry, 0);
        check("abort_out_is_zero", out_is_zero, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);

        run_op("add_after_rst", 4'b0010, 8'h01, 8'h02, 8'h03, 1'b0, 1, 0, 0);

        // Back-to-back single-cycle ops keep done high
        @(negedge clk);
        opcode = 4'b0011;
        in_a   = 8'hF0;
        in_b   = 8'h3C;
        start  = 1'b1;
        e.o = 8'h30; e.c = 1'b0; e.z = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        check("b2b_done1", done, 1);
        opcode = 4'b0000;
        in_a   = 8'h55;
        e.o = 8'h55; e.c = 1'b0; e.z = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done2", done, 1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
